// File: rtl/muldiv.sv
`default_nettype none
// ============================================================================
// Module      : muldiv
// Description : Iterative RV32M multiply/divide unit, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_MULHU  = 3'd3;
    localparam logic [2:0] c_OP_DIV    = 3'd4;
    localparam logic [2:0] c_OP_DIVU   = 3'd5;
    localparam logic [2:0] c_OP_REM    = 3'd6;
    localparam logic [2:0] c_OP_REMU   = 3'd7;

    localparam logic [31:0] c_INT_MIN = 32'h8000_0000;
    localparam logic [31:0] c_ALL_ONE = 32'hFFFF_FFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [2:0]  r_op;
    logic        r_neg;
    logic [31:0] r_a;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_out;

    logic        w_accept;
    logic        w_sign1;
    logic        w_sign2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_res;
    logic        w_neg_init;

    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_dsub;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [63:0] w_prod;
    logic [63:0] w_prod_s;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_result;

    assign req_ready  = (r_state == c_ST_IDLE);
    assign resp_valid = (r_state == c_ST_DONE);
    assign busy       = (r_state != c_ST_IDLE);
    assign out        = r_out;
    assign w_accept   = req_valid && req_ready;

    // Operand signs and magnitudes; |INT_MIN| stays 0x80000000 read as unsigned.
    assign w_sign1 = in1[31] && (op == c_OP_MULH || op == c_OP_MULHSU ||
                                 op == c_OP_DIV  || op == c_OP_REM);
    assign w_sign2 = in2[31] && (op == c_OP_MULH || op == c_OP_DIV || op == c_OP_REM);
    assign w_mag1  = w_sign1 ? (32'd0 - in1) : in1;
    assign w_mag2  = w_sign2 ? (32'd0 - in2) : in2;

    // Remainders follow the dividend sign, everything else the sign product.
    assign w_neg_init = (op[2] && op[1]) ? w_sign1 : (w_sign1 ^ w_sign2);

    assign w_div0    = op[2] && (in2 == 32'd0);
    assign w_ovf     = (op == c_OP_DIV || op == c_OP_REM) &&
                       (in1 == c_INT_MIN) && (in2 == c_ALL_ONE);
    assign w_special = w_div0 || w_ovf;

    always_comb begin
        w_special_res = 32'd0;
        if (w_div0) begin
            w_special_res = op[1] ? in1 : c_ALL_ONE;
        end else if (w_ovf) begin
            w_special_res = op[1] ? 32'd0 : c_INT_MIN;
        end
    end

    // r_hi/r_lo hold {product} for multiply and {remainder, quotient} for divide.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);
    assign w_shift = {r_hi, r_lo[31]};
    assign w_ge    = (w_shift >= {1'b0, r_a});
    assign w_dsub  = w_shift[31:0] - r_a;

    assign w_hi_nxt = r_op[2] ? (w_ge ? w_dsub : w_shift[31:0]) : w_sum[32:1];
    assign w_lo_nxt = r_op[2] ? {r_lo[30:0], w_ge} : {w_sum[0], r_lo[31:1]};

    assign w_prod   = {w_hi_nxt, w_lo_nxt};
    assign w_prod_s = r_neg ? (64'd0 - w_prod) : w_prod;
    assign w_quot   = r_neg ? (32'd0 - w_lo_nxt) : w_lo_nxt;
    assign w_rem    = r_neg ? (32'd0 - w_hi_nxt) : w_hi_nxt;

    always_comb begin
        w_result = 32'd0;
        case (r_op)
            c_OP_MUL:                           w_result = w_prod_s[31:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_result = w_prod_s[63:32];
            c_OP_DIV, c_OP_DIVU:                w_result = w_quot;
            c_OP_REM, c_OP_REMU:                w_result = w_rem;
            default:                            w_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? c_ST_DONE : c_ST_CALC;
                end
            end
            c_ST_CALC: begin
                if (r_cnt == 5'd31) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (resp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 5'd0;
            r_op  <= 3'd0;
            r_neg <= 1'b0;
            r_a   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_out <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_neg <= w_neg_init;
                        r_a   <= op[2] ? w_mag2 : w_mag1;
                        r_hi  <= 32'd0;
                        r_lo  <= op[2] ? w_mag1 : w_mag2;
                        r_cnt <= 5'd0;
                        if (w_special) begin
                            r_out <= w_special_res;
                        end
                    end
                end
                c_ST_CALC: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_out <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv
// Description : Self-checking bench for muldiv against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    muldiv #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .in1        (in1),
        .in2        (in2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .out        (out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return (f[2] && b == 32'd0) ||
               ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ub = longint'(b);
        r  = 32'd0;
        case (f)
            3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else begin p = 64'(sa / sb); r = p[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else begin p = 64'(sa % sb); r = p[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one operation from an idle unit, garble inputs after accept,
    // wait for the response and hand it off; rdy is req_ready after handoff.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic rdy);
        op = f; in1 = a; in2 = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        op = 3'($urandom); in1 = $urandom; in2 = $urandom;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            resp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        res = out;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        rdy = req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0 || out !== 32'd0) begin
            bad++;
            $display("FAIL reset: ready=%b valid=%b busy=%b out=%h, want 1 0 0 00000000",
                     req_ready, resp_valid, busy, out);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  fv [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                 3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd1};
        logic [31:0] av [14] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                 32'd5, 32'd5, 32'h80000000, 32'h80000000,
                                 32'h80000000, 32'h80000000};
        logic [31:0] bv [14] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                 32'd2, 32'd2, 32'd7, 32'd7,
                                 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd2, 32'h80000000};
        logic [31:0] ev [14] = '{32'h2A, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0,
                                 32'hC0000000, 32'h40000000};
        int          lv [14] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33, 33};
        logic [31:0] res;
        int          lat;
        logic        rdy;
        for (int i = 0; i < 14; i++) begin
            do_op(fv[i], av[i], bv[i], res, lat, rdy);
            total++;
            if (res !== ev[i]) begin
                bad++;
                $display("FAIL directed[%0d] result: got %h want %h", i, res, ev[i]);
            end
            total++;
            if (lat != lv[i]) begin
                bad++;
                $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, lv[i]);
            end
            total++;
            if (rdy !== 1'b1) begin
                bad++;
                $display("FAIL directed[%0d] ready after handoff: got %b want 1", i, rdy);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res, exp;
        int          lat, elat;
        logic        rdy;
        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            exp  = model(f, a, b);
            elat = is_special(f, a, b) ? 1 : 33;
            do_op(f, a, b, res, lat, rdy);
            total++;
            if (res !== exp || lat != elat) begin
                bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                         i, f, a, b, res, lat, exp, elat);
            end
        end
    endtask

    // Hold the response for 10 cycles while a second request waits on req_ready.
    task automatic test_backpressure();
        logic [31:0] a1, b1, a2, b2, held, exp1, exp2, res;
        logic [2:0]  f2;
        int          lat, elat;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom | 32'd1;
        f2 = 3'($urandom_range(4, 7));
        exp1 = model(3'd3, a1, b1);
        exp2 = model(f2, a2, b2);
        elat = is_special(f2, a2, b2) ? 1 : 33;
        op = 3'd3; in1 = a1; in2 = b1; req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        op = f2; in1 = a2; in2 = b2;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (out !== exp1 || lat != 33) begin
            bad++;
            $display("FAIL bp first: got %h lat %0d want %h lat 33", out, lat, exp1);
        end
        held = out;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (resp_valid !== 1'b1 || out !== held || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp hold[%0d]: valid=%b out=%h ready=%b want 1 %h 0",
                         i, resp_valid, out, req_ready, held);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp release: ready=%b valid=%b want 1 0", req_ready, resp_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (out !== exp2 || lat != elat) begin
            bad++;
            $display("FAIL bp pending op=%0d: got %h lat %0d want %h lat %0d",
                     f2, out, lat, exp2, elat);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] res;
        int          lat, seen;
        logic        rdy;
        op = 3'd0; in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5679; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0 || out !== 32'd0) begin
            bad++;
            $display("FAIL abort state: ready=%b valid=%b busy=%b out=%h, want 1 0 0 00000000",
                     req_ready, resp_valid, busy, out);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1 || busy === 1'b1) seen++;
        end
        resp_ready = 1'b0;
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort no response: active cycles %0d want 0", seen);
        end
        do_op(3'd0, 32'd3, 32'd3, res, lat, rdy);
        total++;
        if (res !== 32'd9 || lat != 33) begin
            bad++;
            $display("FAIL abort recovery: got %h lat %0d want 00000009 lat 33", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  execute stage presents an operation.
REQ-005 req_ready  output  1  unit can accept an operation this cycle.
REQ-006 op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 in1  input  32  rs1 operand (multiplicand / dividend).
REQ-008 in2  input  32  rs2 operand (multiplier / divisor).
REQ-009 resp_valid  output  1  out holds a finished result.
REQ-010 resp_ready  input  1  consumer takes the result this cycle.
REQ-011 out  output  32  result.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, CALC, DONE. req_ready SHALL be 1 only in IDLE. resp_valid SHALL be 1 only in DONE.
REQ-014 Accept = req_valid && req_ready at a rising edge. On accept, op, in1 and in2 SHALL be captured. Input changes after accept SHALL have no effect.
REQ-015 IDLE->CALC on accept, except for the special cases in REQ-020/021. IDLE->DONE on accept of a special case.
REQ-016 CALC SHALL run exactly 32 iterations using a 5-bit counter that starts at 0. CALC->DONE on the edge where the counter equals 31.
- Normal latency: resp_valid rises 33 cycles after the accept edge.
- Special-case latency: resp_valid rises 1 cycle after the accept edge.
REQ-017 DONE: out and resp_valid SHALL hold stable until resp_valid && resp_ready. Then DONE->IDLE. req_ready rises the following cycle; there is no same-cycle accept out of DONE.
REQ-018 Multiply: iterative shift-add on magnitudes, producing a 64-bit product P.
- Signed operands: in1 for MULH and MULHSU; in2 for MULH only.
- P SHALL be two's-complement negated when exactly one signed operand is negative.
- MUL returns P[31:0]; MULH, MULHSU and MULHU return P[63:32].
REQ-019 Divide: restoring shift-subtract on magnitudes, one quotient bit per iteration.
- DIV and REM take operand signs; DIVU and REMU are unsigned.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-020 Divide by zero (in2==0): DIV/DIVU return 0xFFFFFFFF; REM/REMU return in1. Special case.
REQ-021 Signed overflow (DIV/REM with in1==0x80000000, in2==0xFFFFFFFF): DIV returns 0x80000000; REM returns 0. Special case.
REQ-022 Magnitude of 0x80000000 SHALL be handled as unsigned 2^31; no truncation error.
REQ-023 resp_ready while not in DONE SHALL be ignored. req_valid while busy SHALL NOT be accepted and SHALL NOT be lost by the producer, because req_ready is 0.

Reset
REQ-024 rst high at an edge SHALL force IDLE, counter 0, and all datapath registers 0. This holds in any state, including mid-CALC and mid-DONE, and overrides any simultaneous accept or response handshake.
REQ-025 Values in the cycle after reset: req_ready=1, resp_valid=0, busy=0, out=0.
REQ-026 An aborted operation SHALL produce no response.

Verification
REQ-027 MUL in1=7, in2=6, resp_ready=1 -> out=0x0000002A; resp_valid rises exactly 33 cycles after accept; req_ready=1 one cycle after the response handshake.
REQ-028 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU in1=0xFFFFFFFF, in2=2 -> 0xFFFFFFFF.
REQ-029 DIV in1=-7 (0xFFFFFFF9), in2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU in1=100, in2=7 -> 14; REMU same operands -> 2.
REQ-030 DIVU x/0 with in1=5 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0. Each response arrives 1 cycle after accept.
REQ-031 Backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_valid and out stable and req_ready=0 throughout. Assert resp_ready -> IDLE next cycle.
REQ-032 Assert rst at CALC iteration 15 -> next cycle IDLE with outputs per REQ-025 and no response. A new MUL 3x3 then returns 9 with normal latency.
